serial_receive_sefunmi: RTL

Serial receiver for the 9-bit parity channel. It accepts a framed, bit-serial stream on a single line, samples each bit at mid-period, and reassembles the 9-bit payload. It checks the even-parity bit and the stop bit, then presents the word with a one-cycle valid strobe or an error strobe. It is the far end of a serialised link whose transmitter frames the same 10-bit data+parity word the channel already carries.

---
 rtl/serial_receive_sefunmi.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/serial_receive_sefunmi.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | serial_receive_sefunmi                                                      |
// | Framed bit-serial receiver: 9 data bits, even parity, one stop bit.         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module serial_receive_sefunmi #(
    parameter int BIT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       serial_in,
    output logic [8:0] data_received,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    // The counter counts down to 0 and samples there, so loads are one less than the period.
    localparam logic [CW-1:0] C_HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] C_BIT_M1  = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            prev_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      bit_idx_q;
    logic [8:0]      shift_q;
    logic            par_q;
    logic [8:0]      data_q;
    logic            valid_q;
    logic            perr_q;
    logic            ferr_q;
    logic            busy_q;

    logic            fall_d;
    logic            at_sample_d;
    logic [8:0]      shift_d;
    logic            par_bad_d;

    assign fall_d      = prev_q & ~sync2_q;
    assign at_sample_d = (cnt_q == '0);
    assign shift_d     = {sync2_q, shift_q[8:1]};
    assign par_bad_d   = ^{shift_q, par_q};

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= 4'd0;
            shift_q   <= 9'h000;
            par_q     <= 1'b0;
            data_q    <= 9'h000;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;

            if (state_q != S_IDLE && !at_sample_d) begin
                cnt_q <= cnt_q - 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (fall_d) begin
                        state_q <= S_START;
                        cnt_q   <= C_HALF_M1;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (at_sample_d) begin
                        if (!sync2_q) begin
                            state_q   <= S_DATA;
                            cnt_q     <= C_BIT_M1;
                            bit_idx_q <= 4'd0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (at_sample_d) begin
                        shift_q   <= shift_d;
                        cnt_q     <= C_BIT_M1;
                        bit_idx_q <= bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd8) begin
                            state_q <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_sample_d) begin
                        par_q   <= sync2_q;
                        cnt_q   <= C_BIT_M1;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_sample_d) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        data_q  <= shift_q;
                        // A bad stop bit outranks a parity fault.
                        if (!sync2_q) begin
                            ferr_q <= 1'b1;
                        end else if (par_bad_d) begin
                            perr_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_received = data_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire
